// File: rtl/rand_range_gen.sv
// Mask-and-reject sampler: turns a free-running 16-bit LFSR word into uniform samples in [0, limit),
// buffered through a small output FIFO. Define RAND_STATS_EN to add the rej_cnt reject counter port.
module rand_range_gen #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] lfsr_in,
  input  logic        start,
  input  logic [15:0] limit,
  input  logic [15:0] count,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
`ifdef RAND_STATS_EN
  ,
  output logic [15:0] rej_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [15:0]      lim_q;
  logic [15:0]      mask_q;
  logic [15:0]      remaining_q;
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic [15:0]      cand;
  logic             full;
  logic             accept;
  logic             push;
  logic             pop;
  logic             start_ok;
  logic             drain_empty;

  // Smallest all-ones mask covering limit-1; limit 0 stands for 65536 and wraps to 0xFFFF.
  function automatic logic [15:0] range_mask(input logic [15:0] l);
    logic [15:0] m;
    m = l - 16'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m;
  endfunction

  function automatic logic in_range(input logic [15:0] c, input logic [15:0] l);
    logic [16:0] bound;
    bound = (l == 16'd0) ? 17'h10000 : {1'b0, l};
    return ({1'b0, c} < bound);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign start_ok    = (state == IDLE) && start;
  assign cand        = lfsr_in & mask_q;
  assign full        = (occ == OCC_W'(DEPTH));
  assign accept      = in_range(cand, lim_q);
  assign push        = (state == RUN) && !full && accept;
  assign pop         = out_valid && out_ready;
  assign out_valid   = (occ != '0);
  assign out_data    = out_valid ? mem[rd_ptr] : 16'd0;
  // DRAIN never pushes, so the FIFO is empty next cycle when it is empty now or its last entry leaves.
  assign drain_empty = (occ == '0) || ((occ == OCC_W'(1)) && pop);

  // Sample datapath: run parameters and FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand;
    if (start_ok) begin
      lim_q       <= limit;
      mask_q      <= range_mask(limit);
      remaining_q <= count;
    end else if (push) begin
      remaining_q <= remaining_q - 16'd1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Run control FSM with registered busy/done
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push && (remaining_q == 16'd1)) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAND_STATS_EN
  // Reject statistics: only candidates actually evaluated against a non-full FIFO count
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rej_cnt <= 16'd0;
    end else if (start_ok) begin
      rej_cnt <= 16'd0;
    end else if ((state == RUN) && !full && !accept) begin
      rej_cnt <= sat_inc(rej_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rand_range_gen.sv
// Bench for rand_range_gen: randomized LFSR/handshake stimulus checked every cycle against a
// queue-based reference model, plus directed scenarios for reject, full range, backpressure and reset.
module tb_rand_range_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] lfsr_in;
  logic        start;
  logic [15:0] limit;
  logic [15:0] count;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef RAND_STATS_EN
  logic [15:0] rej_cnt;
`endif

  always #5 clk = ~clk;

  rand_range_gen #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .lfsr_in   (lfsr_in),
    .start     (start),
    .limit     (limit),
    .count     (count),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef RAND_STATS_EN
    ,
    .rej_cnt   (rej_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: run phase, latched parameters and the FIFO as a plain queue
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_t;
  mphase_t ph = M_IDLE;
  int m_leff = 1;
  int m_mask = 0;
  int m_rem  = 0;
  int m_rej  = 0;
  int q[$];

  int log_q[$];
  int lfsr_seq[$];
  int done_seen = 0;

  task automatic model_step();
    bit pop;
    bit push;
    int cand;
    int lm1;
    int k;
    pop  = (q.size() > 0) && out_ready;
    push = 0;
    cand = 0;
    if (!resetn) begin
      ph = M_IDLE;
      q.delete();
      m_rej = 0;
      return;
    end
    case (ph)
      M_IDLE: if (start) begin
        m_leff = (limit == 16'd0) ? 65536 : int'(limit);
        m_rem  = int'(count);
        m_rej  = 0;
        lm1 = m_leff - 1;
        k = 0;
        while ((lm1 >> k) != 0) k++;
        m_mask = (1 << k) - 1;
        ph = (count == 16'd0) ? M_DONE : M_RUN;
      end
      M_RUN: begin
        cand = int'(lfsr_in) & m_mask;
        if (q.size() < DEPTH) begin
          if (cand < m_leff) begin
            push = 1;
            m_rem--;
            if (m_rem == 0) ph = M_DRAIN;
          end else if (m_rej < 65535) begin
            m_rej++;
          end
        end
      end
      M_DRAIN: if (q.size() - (pop ? 1 : 0) == 0) ph = M_DONE;
      M_DONE:  ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(cand);
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, (q.size() > 0));
    check("out_data",  out_data,  (q.size() > 0) ? q[0] : 0);
    check("busy",      busy,      (ph == M_RUN) || (ph == M_DRAIN));
    check("done",      done,      (ph == M_DONE));
`ifdef RAND_STATS_EN
    check("rej_cnt",   rej_cnt,   m_rej);
`endif
    if (done) done_seen++;
  endtask

  task automatic tick();
    if (out_valid && out_ready) log_q.push_back(int'(out_data));
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  function automatic int getlog(input int i);
    return (i < log_q.size()) ? log_q[i] : -1;
  endfunction

  task automatic start_run(input logic [15:0] lim, input logic [15:0] cnt);
    log_q.delete();
    done_seen = 0;
    limit   = lim;
    count   = cnt;
    start   = 1'b1;
    lfsr_in = 16'($urandom);
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int rdy_mode, input int bound, output int ncyc);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < bound) begin
      lfsr_in   = (lfsr_seq.size() > 0) ? 16'(lfsr_seq.pop_front()) : 16'($urandom);
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      limit     = 16'($urandom);
      count     = 16'($urandom);
      tick();
      n++;
      seen = done;
    end
    ncyc = n;
    check("done_reached", seen, 1);
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    int ncyc;
    int n;
    int sum;
    logic [15:0] bp_vals [10];

    resetn = 1'b0; start = 1'b0; lfsr_in = 16'd0; limit = 16'd0; count = 16'd0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data,  0);
    check("rst_busy",  busy,      0);
    resetn = 1'b1;
    tick();

    // Basic reject
    start_run(16'd10, 16'd2);
    lfsr_seq = '{16'h0003, 16'hFFFC, 16'h000F, 16'h1239};
    run_until_done(0, 50, ncyc);
    check("basic_n",    log_q.size(), 2);
    check("basic_0",    getlog(0), 3);
    check("basic_1",    getlog(1), 9);
    check("basic_done", done_seen, 1);
`ifdef RAND_STATS_EN
    check("basic_rej",  rej_cnt, 2);
`endif

    // Full range with minimum run length
    start_run(16'd0, 16'd4);
    lfsr_seq = '{16'hFFFF, 16'h0000, 16'h8000, 16'h1234};
    run_until_done(0, 50, ncyc);
    check("full_latency", ncyc, 5);
    check("full_n", log_q.size(), 4);
    check("full_0", getlog(0), 32'hFFFF);
    check("full_1", getlog(1), 0);
    check("full_2", getlog(2), 32'h8000);
    check("full_3", getlog(3), 32'h1234);

    // Backpressure
    bp_vals = '{16'h0005, 16'h123A, 16'hFFF3, 16'h0F0C, 16'h7771, 16'h0002,
                16'h4448, 16'hAAAE, 16'h0009, 16'h1110};
    out_ready = 1'b0;
    start_run(16'd16, 16'd6);
    for (int i = 0; i < 10; i++) begin
      lfsr_in = bp_vals[i];
      tick();
    end
    check("bp_valid", out_valid, 1);
    check("bp_head",  out_data, 32'h5);
    check("bp_nopop", log_q.size(), 0);
    run_until_done(0, 50, ncyc);
    check("bp_n", log_q.size(), 6);
    check("bp_0", getlog(0), 32'h5);
    check("bp_1", getlog(1), 32'hA);
    check("bp_2", getlog(2), 32'h3);
    check("bp_3", getlog(3), 32'hC);
`ifdef RAND_STATS_EN
    check("bp_rej", rej_cnt, 0);
`endif

    // Zero count, then L=1
    start_run(16'd5, 16'd0);
    check("zc_done", done, 1);
    tick();
    check("zc_idle", busy, 0);
    start_run(16'd1, 16'd3);
    run_until_done(0, 50, ncyc);
    sum = 0;
    foreach (log_q[i]) sum += log_q[i];
    check("l1_n",   log_q.size(), 3);
    check("l1_sum", sum, 0);

    // Reset mid-run
    start_run(16'd100, 16'd50);
    n = 0;
    while (log_q.size() < 5 && n < 200) begin
      lfsr_in = 16'($urandom);
      tick();
      n++;
    end
    check("mid_progress", (log_q.size() >= 5), 1);
    resetn = 1'b0;
    tick();
    check("mid_busy",  busy, 0);
    check("mid_valid", out_valid, 0);
`ifdef RAND_STATS_EN
    check("mid_rej",   rej_cnt, 0);
`endif
    resetn = 1'b1;
    tick();
    start_run(16'd7, 16'd5);
    run_until_done(1, 300, ncyc);
    check("post_rst_n", log_q.size(), 5);

    // Start while busy is ignored
    start_run(16'd50, 16'd3);
    start = 1'b1; count = 16'd9; limit = 16'd50; lfsr_in = 16'($urandom);
    tick();
    start = 1'b0;
    run_until_done(0, 100, ncyc);
    check("busy_start_n", log_q.size(), 3);

    // Random runs
    for (int r = 0; r < 8; r++) begin
      logic [15:0] lim;
      logic [15:0] cnt;
      lim = (r == 3) ? 16'd0 : 16'($urandom_range(1, 300));
      cnt = 16'($urandom_range(1, 12));
      start_run(lim, cnt);
      run_until_done(1, 600, ncyc);
      check("rand_n", log_q.size(), int'(cnt));
      check("rand_done", done_seen, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_range_gen.md
# rand_range_gen

Converts the free-running 16-bit pseudo-random word from `lfsr1` into a stream of unbiased integers uniformly distributed in [0, limit), using mask-and-reject sampling. It sits directly downstream of `lfsr1` and feeds random indices and initial values to the digit-recognition datapath through a valid/ready output backed by a small FIFO. A run is started by a one-cycle `start` pulse and produces exactly `count` samples.

## Interface
- `DEPTH`, 4: output FIFO depth in entries; must be a power of 2, minimum 2.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `resetn`  in  1: synchronous, active-low reset.
- `lfsr_in`  in  16: current LFSR output, which changes every cycle. It is connected directly to `lfsr1.lfsr_out`.
- `start`  in  1: one-cycle pulse that begins a run. It is honoured only in IDLE.
- `limit`  in  16: exclusive upper bound of the output range, sampled on `start`. A value of 0 means 65536.
- `count`  in  16: number of samples to produce, sampled on `start`.
- `out_data`  out  16: sample at the FIFO head.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `busy`  out  1: high in RUN and DRAIN.
- `done`  out  1: one-cycle pulse when a run completes.
- `rej_cnt`  out  16: rejected candidates in the current run. This port exists only with `RAND_STATS_EN`.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE + `start`:**
  - Latch `limit` into L and `count` into `remaining`.
  - Compute `mask` = 2^k − 1, where k is the bit length of (L − 1).
  - Examples: L=1 gives mask 0x0000. L=10 gives 0x000F. L=16 gives 0x000F. L=17 gives 0x001F. L=0 gives 0xFFFF.
  - If `count` = 0, go to DONE. Otherwise go to RUN.
- **RUN, each cycle:**
  - `cand` = `lfsr_in` & `mask`.
  - If the FIFO is not full (registered occupancy < DEPTH):
    - Accept when `cand` < L, or always when L = 0. An accepted candidate is pushed and `remaining` decrements.
    - Otherwise the candidate is rejected.
  - If the FIFO is full, the candidate is discarded and is not counted as a reject.
  - When `remaining` reaches 0 after a push, go to DRAIN.
- **DRAIN:** wait until the FIFO is empty, then go to DONE.
- **DONE:** assert `done` for one cycle, then return to IDLE.
- **Restrictions:**
  - `start` is ignored outside IDLE.
  - Latched `limit` and `count` are unaffected by input changes mid-run.
- **FIFO:**
  - A pop happens when `out_valid` && `out_ready`.
  - Push and pop in the same cycle are allowed whenever the push condition holds. Occupancy is unchanged in that case.
  - The push condition uses occupancy at the start of the cycle. A pop does not free space for a same-cycle push when the FIFO is full.
  - Read and write pointers wrap modulo DEPTH.
- **Arithmetic:** the compare is 17-bit unsigned, so L = 0 is treated as 65536. `remaining` is 16-bit and never underflows.
- **Reset:** `resetn` low at any time, including mid-run, returns the FSM to IDLE and empties the FIFO. Pending samples are lost, `done` is not pulsed and `rej_cnt` is cleared.

## Timing
- **Reset values:** `out_data` = 0, `out_valid` = 0, `busy` = 0, `done` = 0, `rej_cnt` = 0.
- **Start to first candidate:** `start` sampled at edge t moves to RUN at t. The first candidate is evaluated in cycle t+1.
- **Push to output latency:** 1 cycle. A candidate pushed at edge t into an empty FIFO gives `out_valid` = 1 after t. There is no combinational bypass from `lfsr_in` to `out_data`.
- **Hold rule:** `out_data` and `out_valid` stay stable while `out_valid` && !`out_ready`.
- **`busy`:** goes high the cycle after `start` and low in the same cycle `done` is high.
- **Minimum run length:** `count` = N with no rejects and `out_ready` held at 1 has `done` asserted N + 2 cycles after `start`.

## Configuration
- **Macro:** `RAND_STATS_EN`.
- **Defined:**
  - The `rej_cnt` port exists.
  - `rej_cnt` increments on each rejected candidate in RUN, saturating at 0xFFFF.
  - It clears on an accepted `start` and holds its value through IDLE until the next `start`.
- **Undefined:** the `rej_cnt` port and counter are absent. Sampling behaviour is identical.

## Test plan
- **Basic reject:** `limit`=10, `count`=2, `out_ready`=1, `lfsr_in` sequence 0x0003, 0xFFFC, 0x000F, 0x1239 → `out_data` 3 then 9, one `done` pulse, `rej_cnt`=2.
- **Full range:** `limit`=0, `count`=4, `lfsr_in` 0xFFFF, 0x0000, 0x8000, 0x1234 → all four emitted unchanged, `rej_cnt`=0.
- **Backpressure:** DEPTH=4, `limit`=16, `count`=6, `out_ready`=0 for 10 cycles → FIFO holds 4, `out_data`=first sample stable, `rej_cnt`=0. Release `out_ready` → remaining 2 emitted in order, then `done`.
- **Zero count / L=1:** `count`=0 → `done` 1 cycle after `start`, `out_valid` never high. `limit`=1, `count`=3 → three zeros, no rejects.
- **Reset mid-run:** `limit`=100, `count`=50, deassert `resetn` after 5 samples → next cycle `busy`=0, `out_valid`=0, `rej_cnt`=0. A new `start` runs normally.
- **Start while busy:** pulse `start` with `count`=9 during RUN → ignored, original count of samples produced.
